// File: rtl/regfile_sequencer.sv
// Control sequencer for a 4 x 10-bit register file: decodes one instruction
// per Exec handshake and drives the read/write/ALU/bus controls over the
// 1-2 execute cycles that LOAD, COPY and ALU operations need.
module regfile_sequencer #(
  parameter int INSTR_W = 10,
  parameter int ADDR_W  = 2
) (
  input  logic               CLKb,
  input  logic               RSTb,
  input  logic               Exec,
  input  logic [INSTR_W-1:0] INSTR,
  output logic               ENW,
  output logic [ADDR_W-1:0]  WRA,
  output logic               ENR0,
  output logic [ADDR_W-1:0]  RDA0,
  output logic               ENR1,
  output logic [ADDR_W-1:0]  RDA1,
  output logic [2:0]         ALUop,
  output logic               Gin,
  output logic [1:0]         BusSel,
  output logic               Busy,
  output logic               Done,
  output logic               Err
);

  typedef enum logic [1:0] {IDLE, T1, T2} state_t;

  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_EXT  = 2'b01;
  localparam logic [1:0] BUS_Q0   = 2'b10;
  localparam logic [1:0] BUS_G    = 2'b11;

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] ir;

  // Fixed instruction fields; the two low bits carry nothing.
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] rx, ry;
  logic              is_load, is_copy, is_alu;
  logic [2:0]        alu_fn;
  logic              unused_ir_bits;

  assign opcode  = ir[9:6];
  assign rx      = ir[5:4];
  assign ry      = ir[3:2];
  assign is_load = (opcode == 4'b0000);
  assign is_copy = (opcode == 4'b0001);
  assign is_alu  = (opcode[3] == 1'b0) && (opcode[2:1] != 2'b00);
  // Opcodes 0010..0111 map onto ALU functions 000..101.
  assign alu_fn  = opcode[2:0] - 3'd2;
  assign unused_ir_bits = &{1'b0, ir[1:0]};

  // State and instruction register; IR only loads on an accepted Exec.
  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && Exec) ir <= INSTR;
    end
  end

  // Next state and Moore outputs, decoded from state and IR only.
  always_comb begin
    state_nxt = state;
    ENW    = 1'b0;
    WRA    = '0;
    ENR0   = 1'b0;
    RDA0   = '0;
    ENR1   = 1'b0;
    RDA1   = '0;
    ALUop  = 3'b000;
    Gin    = 1'b0;
    BusSel = BUS_NONE;
    Busy   = (state != IDLE);
    Done   = 1'b0;
    Err    = 1'b0;
    unique case (state)
      IDLE: begin
        if (Exec) state_nxt = T1;
      end
      T1: begin
        state_nxt = IDLE;
        if (is_load) begin
          BusSel = BUS_EXT;
          ENW    = 1'b1;
          WRA    = rx;
          Done   = 1'b1;
        end else if (is_copy) begin
          ENR0   = 1'b1;
          RDA0   = ry;
          BusSel = BUS_Q0;
          ENW    = 1'b1;
          WRA    = rx;
          Done   = 1'b1;
        end else if (is_alu) begin
          // Operand fetch and G capture; write-back happens in T2.
          ENR0      = 1'b1;
          RDA0      = rx;
          ENR1      = 1'b1;
          RDA1      = ry;
          ALUop     = alu_fn;
          Gin       = 1'b1;
          state_nxt = T2;
        end else begin
          Done = 1'b1;
          Err  = 1'b1;
        end
      end
      T2: begin
        state_nxt = IDLE;
        BusSel    = BUS_G;
        ENW       = 1'b1;
        WRA       = rx;
        ALUop     = alu_fn;
        Done      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Randomized and directed bench for regfile_sequencer against a per-cycle
// output model derived from the instruction-level behaviour.
module tb_regfile_sequencer;

  logic       CLKb, RSTb, Exec;
  logic [9:0] INSTR;
  logic       ENW, ENR0, ENR1, Gin, Busy, Done, Err;
  logic [1:0] WRA, RDA0, RDA1, BusSel;
  logic [2:0] ALUop;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       enw;
    logic [1:0] wra;
    logic       enr0;
    logic [1:0] rda0;
    logic       enr1;
    logic [1:0] rda1;
    logic [2:0] aluop;
    logic       gin;
    logic [1:0] bussel;
    logic       busy;
    logic       done;
    logic       err;
  } outs_t;

  regfile_sequencer dut (
    .CLKb(CLKb), .RSTb(RSTb), .Exec(Exec), .INSTR(INSTR),
    .ENW(ENW), .WRA(WRA), .ENR0(ENR0), .RDA0(RDA0), .ENR1(ENR1), .RDA1(RDA1),
    .ALUop(ALUop), .Gin(Gin), .BusSel(BusSel), .Busy(Busy), .Done(Done), .Err(Err)
  );

  initial CLKb = 1'b0;
  always #5 CLKb = ~CLKb;

  function automatic outs_t sample();
    outs_t o;
    o = '{enw:ENW, wra:WRA, enr0:ENR0, rda0:RDA0, enr1:ENR1, rda1:RDA1,
          aluop:ALUop, gin:Gin, bussel:BusSel, busy:Busy, done:Done, err:Err};
    return o;
  endfunction

  // Number of execute cycles an instruction occupies.
  function automatic int n_cycles(logic [9:0] ins);
    int opc;
    opc = int'(ins[9:6]);
    return (opc >= 2 && opc <= 7) ? 2 : 1;
  endfunction

  // Expected outputs in execute cycle 'ph' (1 or 2) of instruction 'ins'.
  function automatic outs_t model(logic [9:0] ins, int ph);
    outs_t e;
    int opc;
    e = '0;
    opc = int'(ins[9:6]);
    e.busy = 1'b1;
    if (opc == 0) begin
      e.bussel = 2'b01; e.enw = 1'b1; e.wra = ins[5:4]; e.done = 1'b1;
    end else if (opc == 1) begin
      e.enr0 = 1'b1; e.rda0 = ins[3:2]; e.bussel = 2'b10;
      e.enw = 1'b1; e.wra = ins[5:4]; e.done = 1'b1;
    end else if (opc <= 7) begin
      e.aluop = 3'(opc - 2);
      if (ph == 1) begin
        e.enr0 = 1'b1; e.rda0 = ins[5:4];
        e.enr1 = 1'b1; e.rda1 = ins[3:2];
        e.gin  = 1'b1;
      end else begin
        e.bussel = 2'b11; e.enw = 1'b1; e.wra = ins[5:4]; e.done = 1'b1;
      end
    end else begin
      e.done = 1'b1; e.err = 1'b1;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge CLKb);
    #1;
  endtask

  task automatic test_reset();
    outs_t o;
    RSTb = 1'b0; Exec = 1'b1; INSTR = 10'b0000_10_00_00;
    tick(); tick();
    o = sample();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_hold got %h exp %h", o, outs_t'('0));
    end
    Exec = 1'b0;
    RSTb = 1'b1;
    tick();
    o = sample();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_release got %h exp %h", o, outs_t'('0));
    end
  endtask

  task automatic test_directed();
    logic [9:0] tbl [6];
    outs_t o, e;
    tbl[0] = 10'b0000_10_00_00;  // LOAD R2
    tbl[1] = 10'b0001_11_01_00;  // COPY R3<-R1
    tbl[2] = 10'b0010_00_01_00;  // ADD R0,R1
    tbl[3] = 10'b1010_01_10_00;  // illegal
    tbl[4] = 10'b0011_01_01_11;  // SUB R1,R1
    tbl[5] = 10'b0111_10_11_01;  // NOT
    for (int i = 0; i < 6; i++) begin
      Exec = 1'b1; INSTR = tbl[i];
      tick();
      Exec = 1'b0; INSTR = 10'($urandom);
      for (int p = 1; p <= n_cycles(tbl[i]); p++) begin
        if (p > 1) tick();
        o = sample(); e = model(tbl[i], p);
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL directed[%0d] ph%0d got %h exp %h", i, p, o, e);
        end
      end
      tick();
      o = sample();
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL directed_idle[%0d] got %h exp %h", i, o, outs_t'('0));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] i1, i2;
    int done_cnt, first_k, second_k;
    logic [1:0] wra2;
    i1 = 10'b0011_01_10_00;  // SUB R1,R2
    i2 = 10'b0011_10_01_00;  // SUB R2,R1
    done_cnt = 0; first_k = -1; second_k = -1; wra2 = 2'b00;
    Exec = 1'b1; INSTR = i1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) INSTR = i2;
      if (k == 4) Exec = 1'b0;
      if (k == 3) begin
        checks++;
        if (Busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_gap_busy got %b exp 0", Busy);
        end
      end
      if (Done === 1'b1) begin
        done_cnt++;
        if (first_k < 0) first_k = k;
        else begin
          second_k = k;
          wra2 = WRA;
        end
      end
    end
    checks++;
    if (done_cnt != 2) begin
      errors++;
      $display("FAIL b2b_done_count got %0d exp 2", done_cnt);
    end
    checks++;
    if (first_k != 2 || second_k != 5) begin
      errors++;
      $display("FAIL b2b_done_cycles got %0d,%0d exp 2,5", first_k, second_k);
    end
    checks++;
    if (wra2 !== i2[5:4]) begin
      errors++;
      $display("FAIL b2b_second_wra got %0d exp %0d", wra2, i2[5:4]);
    end
  endtask

  task automatic test_reset_mid();
    outs_t o, e;
    logic [9:0] ld;
    int enw_seen;
    enw_seen = 0;
    Exec = 1'b1; INSTR = 10'b0010_01_10_00;  // ADD R1,R2
    tick();
    Exec = 1'b0;
    RSTb = 1'b0;
    #1;
    o = sample();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_mid_async got %h exp %h", o, outs_t'('0));
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (ENW === 1'b1) enw_seen++;
    end
    RSTb = 1'b1;
    tick();
    if (ENW === 1'b1 || Busy === 1'b1) enw_seen++;
    checks++;
    if (enw_seen != 0) begin
      errors++;
      $display("FAIL reset_mid_no_write got %0d exp 0", enw_seen);
    end
    ld = 10'b0000_11_00_00;
    Exec = 1'b1; INSTR = ld;
    tick();
    Exec = 1'b0;
    o = sample(); e = model(ld, 1);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_mid_load got %h exp %h", o, e);
    end
    tick();
  endtask

  task automatic test_random();
    outs_t o, e;
    logic [9:0] ins;
    int done_cnt, n_acc;
    done_cnt = 0; n_acc = 0;
    for (int i = 0; i < 60; i++) begin
      ins = 10'($urandom);
      Exec = 1'b1; INSTR = ins;
      tick();
      n_acc++;
      for (int p = 1; p <= n_cycles(ins); p++) begin
        if (p > 1) tick();
        // Exec and INSTR toggling while busy must be ignored.
        Exec = 1'($urandom_range(0, 1)); INSTR = 10'($urandom);
        o = sample(); e = model(ins, p);
        if (o.done === 1'b1) done_cnt++;
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL random[%0d] ins %b ph%0d got %h exp %h", i, ins, p, o, e);
        end
      end
      tick();
      Exec = 1'b0;
      o = sample();
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL random_idle[%0d] got %h exp %h", i, o, outs_t'('0));
      end
      repeat ($urandom_range(0, 2)) begin
        tick();
        o = sample();
        checks++;
        if (o !== '0) begin
          errors++;
          $display("FAIL random_gap[%0d] got %h exp %h", i, o, outs_t'('0));
        end
      end
    end
    checks++;
    if (done_cnt != n_acc) begin
      errors++;
      $display("FAIL random_done_count got %0d exp %0d", done_cnt, n_acc);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
Multi-cycle control sequencer that drives the 4-entry x 10-bit register file's write port and its two read ports. It accepts one 10-bit instruction per Exec handshake and decodes it. It then issues the read-address, write-address, enable and bus-source controls for LOAD, COPY and ALU operations over 1-2 execute cycles. It sits between the instruction register/top-level FSM and the datapath (register file, ALU, G result register, shared data bus).

Parameters:
INSTR_W, 10, instruction width. Fields are fixed: opcode = INSTR[9:6], Rx = INSTR[5:4], Ry = INSTR[3:2]; INSTR[1:0] are ignored.
ADDR_W, 2, register-file address width (4 registers).

Ports:
CLKb  in  1  clock; all state changes on rising edge
RSTb  in  1  asynchronous active-low reset
Exec  in  1  start request; sampled only in IDLE
INSTR  in  INSTR_W  instruction; captured on the accepting edge
ENW  out  1  register-file write enable
WRA  out  ADDR_W  register-file write address
ENR0  out  1  read port 0 enable
RDA0  out  ADDR_W  read port 0 address
ENR1  out  1  read port 1 enable
RDA1  out  ADDR_W  read port 1 address
ALUop  out  3  ALU function: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not(port1)
Gin  out  1  load G result register from ALU output
BusSel  out  2  bus source: 00 none, 01 external data, 10 read port 0 (Q0), 11 G
Busy  out  1  high whenever state is not IDLE
Done  out  1  one-cycle pulse in the final cycle of an instruction
Err  out  1  one-cycle pulse, coincident with Done, on an illegal opcode

Behaviour:
- Clock and reset: one clock (CLKb). Reset is asynchronous and active-low (RSTb).
- Reset (RSTb=0, asynchronous, any state): state goes to IDLE and IR clears to 0. All outputs go to 0: ENW, ENR0, ENR1, Gin, Done, Err, Busy = 0; WRA, RDA0, RDA1, ALUop, BusSel = 0. Reset mid-instruction aborts it with no write issued after reset asserts.
- States: IDLE, T1, T2. State and IR are registered. Outputs are decoded from state and IR only; there is no combinational path from Exec or INSTR to any output.
- IDLE:
  - All enables are 0.
  - If Exec=1 at a rising edge: IR <= INSTR and the next state is T1. Otherwise the state stays IDLE.
  - Exec asserted while Busy=1 is ignored; it is not queued.
- LOAD (opcode 0000):
  - T1 drives BusSel=01, ENW=1, WRA=Rx, Done=1.
  - Next state IDLE.
  - Latency: Exec edge -> write edge is 1 cycle.
- COPY (opcode 0001):
  - T1 drives ENR0=1, RDA0=Ry, BusSel=10, ENW=1, WRA=Rx, Done=1.
  - Next state IDLE.
  - COPY with Rx=Ry is legal and writes the same value back.
- ALU ops (opcodes 0010..0111 map to ALUop 000..101):
  - T1 drives ENR0=1, RDA0=Rx, ENR1=1, RDA1=Ry, ALUop, Gin=1. Next state T2.
  - T2 drives BusSel=11, ENW=1, WRA=Rx, Done=1, and holds ALUop. Next state IDLE.
  - NOT ignores port 0 data but still asserts ENR0.
  - Rx=Ry is legal (e.g. SUB R1,R1 writes 0).
- Illegal opcodes (1xxx):
  - T1 drives Done=1, Err=1, ENW=0, BusSel=00.
  - Next state IDLE. No register is modified.
- Exec handshake: Exec is accepted only in IDLE. A new Exec is accepted at the earliest on the edge that ends the cycle after Done. That cycle is an IDLE cycle with Busy=0, so back-to-back throughput is one instruction per 2 (LOAD/COPY) or 3 (ALU) cycles.
- Output invariants:
  - ENW=1 only in the cycle where Done=1 and Err=0.
  - Exactly one Done pulse per accepted Exec unless reset intervenes.
  - Fields that are not enabled (WRA, RDA0, RDA1 when the matching enable is 0) are driven to 0.
- IR stays stable from the accept edge until the next accept edge. INSTR changes while Busy have no effect.

Test Plan:
- Reset mid-ALU: reset during T1 of ADD -> state IDLE, Busy=0, ENW never asserts; a subsequent LOAD executes normally.
- LOAD R2: Exec=1 with INSTR=10'b0000_10_00_00 -> next cycle ENW=1, WRA=2, BusSel=01, Done=1, Busy=1; following cycle Busy=0, all enables 0.
- COPY R3<-R1: INSTR=10'b0001_11_01_00 -> single cycle with ENR0=1, RDA0=1, BusSel=10, ENW=1, WRA=3, Done=1.
- ADD R0,R1: INSTR=10'b0010_00_01_00 -> T1: ENR0=1/RDA0=0, ENR1=1/RDA1=1, ALUop=000, Gin=1, Done=0. T2: BusSel=11, ENW=1, WRA=0, Done=1.
- Exec held high continuously across two SUB instructions -> second accepted only on the edge after the first's Done cycle plus one IDLE cycle; exactly two Done pulses 3 cycles apart.
- Illegal INSTR=10'b1010_01_10_00 -> T1: Done=1, Err=1, ENW=0, BusSel=00; then IDLE.
